// File: rtl/bit_scan_sequencer.sv
// Bit scan sequencer: latches a request vector and emits the indices of its set
// bits one per handshake, highest index first, then pulses done.
module bit_scan_sequencer #(
   parameter int WIDTH = 8,
   localparam int IW = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_bits,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IW-1:0]    out_idx,
   output logic             out_last,
   output logic             done,
   output logic [IW:0]      count
);

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } stateT;

   stateT            state_q, state_d;
   logic [WIDTH-1:0] pending_q, pending_d;
   logic [IW:0]      count_q, count_d;
   logic             done_q, done_d;

   logic [IW:0]      inPop;
   logic [IW-1:0]    topIdx;
   logic             oneLeft;

   always_comb begin
      inPop = '0;
      for (int i = 0; i < WIDTH; i++) begin
         inPop = inPop + {{IW{1'b0}}, in_bits[i]};
      end
   end

   // Later iterations overwrite earlier ones, so the highest set bit wins.
   always_comb begin
      topIdx = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (pending_q[i]) begin
            topIdx = IW'(i);
         end
      end
   end

   assign oneLeft = (pending_q != '0) &&
                    ((pending_q & (pending_q - {{(WIDTH-1){1'b0}}, 1'b1})) == '0);

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      count_d   = count_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               count_d = inPop;
               if (in_bits != '0) begin
                  pending_d = in_bits;
                  state_d   = SCAN;
               end
            end
         end
         SCAN: begin
            if (out_ready) begin
               pending_d[topIdx] = 1'b0;
               if (oneLeft) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         pending_q <= '0;
         count_q   <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         count_q   <= count_d;
         done_q    <= done_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == SCAN);
   assign out_idx   = topIdx;
   assign out_last  = oneLeft;
   assign done      = done_q;
   assign count     = count_q;

endmodule

// File: tb/tb_bit_scan_sequencer.sv
// Self-checking bench for bit_scan_sequencer (WIDTH=8): a queue-based reference
// model checked every cycle, plus directed scenarios with literal expectations.
module tb_bit_scan_sequencer;

   localparam int WIDTH = 8;
   localparam int IW    = 3;

   logic             clk = 1'b0;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_bits;
   logic             out_valid;
   logic             out_ready;
   logic [IW-1:0]    out_idx;
   logic             out_last;
   logic             done;
   logic [IW:0]      count;

   int checks = 0;
   int fails  = 0;

   int          expQ[$];
   logic [IW:0] expCount = '0;
   logic        expDone  = 1'b0;

   bit_scan_sequencer #(.WIDTH(WIDTH)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_bits(in_bits),
      .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
      .out_last(out_last), .done(done), .count(count)
   );

   always #5 clk = ~clk;

   task automatic checkField(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] b,
                                input logic rdy, input logic rst);
      in_valid  = v;
      in_bits   = b;
      out_ready = rdy;
      reset     = rst;
   endtask

   // The model sees a vector as the descending list of its set-bit positions.
   task automatic updateModel();
      if (reset) begin
         expQ.delete();
         expDone  = 1'b0;
         expCount = '0;
      end else begin
         expDone = 1'b0;
         if (expQ.size() == 0) begin
            if (in_valid) begin
               expCount = (IW+1)'($countones(in_bits));
               for (int i = WIDTH-1; i >= 0; i--) begin
                  if (in_bits[i]) expQ.push_back(i);
               end
            end
         end else if (out_ready) begin
            expQ.delete(0);
            if (expQ.size() == 0) expDone = 1'b1;
         end
      end
   endtask

   task automatic checkOutput();
      checkField("model_in_ready", in_ready, expQ.size() == 0);
      checkField("model_out_valid", out_valid, expQ.size() != 0);
      checkField("model_done", done, expDone);
      checkField("model_count", count, expCount);
      checkField("model_out_idx", out_idx, (expQ.size() != 0) ? expQ[0] : 0);
      checkField("model_out_last", out_last, expQ.size() == 1);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         updateModel();
         @(negedge clk);
         checkOutput();
      end
   end

   task automatic waitIdle(input string nm);
      int k = 0;
      while (!in_ready && k < 40) begin
         @(negedge clk);
         k++;
      end
      checkField(nm, in_ready, 1);
   endtask

   initial begin
      int          idxA[3]  = '{7, 5, 2};
      logic        lastA[3] = '{1'b0, 1'b0, 1'b1};
      logic [WIDTH-1:0] rb;

      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      @(negedge clk);
      @(negedge clk);
      checkField("reset_in_ready", in_ready, 1);
      checkField("reset_out_valid", out_valid, 0);
      checkField("reset_count", count, 0);
      checkField("reset_out_idx", out_idx, 0);
      applyStimulus(1'b0, '0, 1'b0, 1'b0);

      // 1010_0100 drained with out_ready high
      @(negedge clk);
      applyStimulus(1'b1, 8'hA4, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         applyStimulus(1'b0, '0, 1'b1, 1'b0);
         checkField("a4_valid", out_valid, 1);
         checkField("a4_idx", out_idx, idxA[i]);
         checkField("a4_last", out_last, lastA[i]);
      end
      @(negedge clk);
      checkField("a4_done", done, 1);
      checkField("a4_count", count, 3);
      checkField("a4_ready", in_ready, 1);
      @(negedge clk);
      checkField("a4_done_pulse", done, 0);

      // zero vector is swallowed
      applyStimulus(1'b1, 8'h00, 1'b1, 1'b0);
      @(negedge clk);
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      checkField("zero_valid", out_valid, 0);
      checkField("zero_count", count, 0);
      checkField("zero_ready", in_ready, 1);
      @(negedge clk);
      checkField("zero_done", done, 0);

      // 0x81 with back-pressure
      applyStimulus(1'b1, 8'h81, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         applyStimulus(1'b0, '0, 1'b0, 1'b0);
         checkField("bp_idx_hold", out_idx, 7);
         checkField("bp_last_hold", out_last, 0);
      end
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      @(negedge clk);
      checkField("bp_idx_second", out_idx, 0);
      checkField("bp_last_second", out_last, 1);
      @(negedge clk);
      checkField("bp_done", done, 1);

      // 0xFF with in_valid held; the 0x3C behind it waits for IDLE
      applyStimulus(1'b1, 8'hFF, 1'b1, 1'b0);
      for (int i = 7; i >= 0; i--) begin
         @(negedge clk);
         applyStimulus(1'b1, 8'h3C, 1'b1, 1'b0);
         checkField("ff_idx", out_idx, i);
         checkField("ff_last", out_last, i == 0);
         checkField("ff_count", count, 8);
      end
      @(negedge clk);
      checkField("ff_done", done, 1);
      checkField("ff_count_hold", count, 8);
      @(negedge clk);
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      checkField("ff_next_count", count, 4);
      checkField("ff_next_idx", out_idx, 5);
      waitIdle("ff_drain");

      // reset mid-scan of 0xC0 after idx 7 is taken
      @(negedge clk);
      applyStimulus(1'b1, 8'hC0, 1'b1, 1'b0);
      @(negedge clk);
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      checkField("c0_first", out_idx, 7);
      @(negedge clk);
      applyStimulus(1'b0, '0, 1'b1, 1'b1);
      checkField("c0_second", out_idx, 6);
      @(negedge clk);
      checkField("c0_rst_valid", out_valid, 0);
      checkField("c0_rst_ready", in_ready, 1);
      checkField("c0_rst_done", done, 0);
      applyStimulus(1'b1, 8'h01, 1'b1, 1'b0);
      @(negedge clk);
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      checkField("one_idx", out_idx, 0);
      checkField("one_last", out_last, 1);
      @(negedge clk);
      checkField("one_done", done, 1);

      // reset wins over a simultaneous request
      applyStimulus(1'b1, 8'h10, 1'b1, 1'b1);
      @(negedge clk);
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      checkField("rstin_ready", in_ready, 1);
      checkField("rstin_valid", out_valid, 0);
      checkField("rstin_count", count, 0);
      @(negedge clk);
      checkField("rstin_still_idle", out_valid, 0);

      // randomized traffic, model checks every cycle
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         rb = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
         applyStimulus(1'($urandom_range(0, 1)), rb,
                       $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0);
      end
      @(negedge clk);
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      waitIdle("final_drain");
      @(negedge clk);
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
